// File: rtl/brick_map.sv
// Brick-wall state for a two-row breakout wall: erase handling, brick count, BCD score
// and a one-cycle registered "live brick at this pixel" query for the renderer.
module brick_map #(
   parameter int unsigned NUM_BRICKS      = 10,
   parameter int unsigned BRICKS_PER_ROW  = 5,
   parameter logic [9:0]  ROW0_Y          = 10'd40,
   parameter logic [9:0]  ROW1_Y          = 10'd90,
   parameter logic [9:0]  BLOCK_WIDTH     = 10'd80,
   parameter logic [9:0]  BLOCK_HEIGHT    = 10'd30,
   parameter logic [9:0]  BLOCK_SPACING_X = 10'd40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       erase_enable,
   input  logic [5:0] e_pos,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       video_on,
   output logic       brick_pixel,
   output logic       brick_row,
   output logic       erase_ack,
   output logic [3:0] bricks_left,
   output logic [7:0] score,
   output logic       all_cleared
);

   logic [NUM_BRICKS-1:0] active;
   logic [NUM_BRICKS-1:0] hit;
   logic [NUM_BRICKS-1:0] hit_row1;
   logic [NUM_BRICKS-1:0] sel;
   logic                  do_erase;
   logic [7:0]            score_next;

   // Per-brick geometry is fixed at elaboration; only the live mask is dynamic.
   for (genvar k = 0; k < NUM_BRICKS; k++) begin : g_brick
      localparam int unsigned COL = k % BRICKS_PER_ROW;
      localparam int unsigned ROW = k / BRICKS_PER_ROW;
      localparam logic [9:0]  X0  = 10'(BLOCK_SPACING_X + (BLOCK_WIDTH + BLOCK_SPACING_X) * COL);
      localparam logic [9:0]  Y0  = (ROW == 0) ? ROW0_Y : ROW1_Y;

      assign hit[k] = active[k]
                    && (pixel_x >= X0) && (pixel_x < X0 + BLOCK_WIDTH)
                    && (pixel_y >= Y0) && (pixel_y < Y0 + BLOCK_HEIGHT);
      assign hit_row1[k] = hit[k] && (ROW != 0);
      assign sel[k]      = (e_pos == 6'(k));
   end

   // Out-of-range indices match no sel bit, so they are ignored naturally.
   assign do_erase = erase_enable && (|(active & sel));

   // BCD +1, holding at 99.
   always_comb begin
      score_next = score;
      if (score != 8'h99) begin
         if (score[3:0] >= 4'd9) score_next = {score[7:4] + 4'd1, 4'd0};
         else                    score_next = {score[7:4], score[3:0] + 4'd1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active      <= '1;
         bricks_left <= 4'(NUM_BRICKS);
         score       <= 8'h00;
         erase_ack   <= 1'b0;
         brick_pixel <= 1'b0;
         brick_row   <= 1'b0;
         all_cleared <= 1'b0;
      end else begin
         brick_pixel <= video_on && (|hit);
         brick_row   <= video_on && (|hit_row1);
         erase_ack   <= do_erase;
         if (do_erase) begin
            active      <= active & ~sel;
            bricks_left <= bricks_left - 4'd1;
            score       <= score_next;
            if (bricks_left == 4'd1) all_cleared <= 1'b1;
         end
      end
   end

endmodule
